// File: rtl/cipher_hash_engine_pkg.sv
// Shared constants, result bundle and transform functions
// for the keyed cipher/hash verification engine.
package cipher_pkg;

    localparam logic [7:0] KEY_DEF  = 8'hA5;
    localparam logic [7:0] ADD_DEF  = 8'h3C;
    localparam logic [2:0] ROT_DEF  = 3'd3;
    localparam logic [7:0] HKEY_DEF = 8'h5A;

    typedef struct packed {
        logic [7:0] dec;
        logic [7:0] reenc;
        logic [7:0] enc;
        logic [7:0] hash;
        logic       valid_flag;
        logic       enc_match;
        logic       hash_match;
    } res_t;

    function automatic logic [7:0] f_rotl(
        input logic [7:0] v,
        input logic [2:0] r
    );
        logic [15:0] t;
        t = {v, v} << r;
        return t[15:8];
    endfunction

    function automatic logic [7:0] f_rotr(
        input logic [7:0] v,
        input logic [2:0] r
    );
        logic [15:0] t;
        t = {v, v} >> r;
        return t[7:0];
    endfunction

    function automatic logic [7:0] f_encrypt(
        input logic [7:0] p,
        input logic [7:0] key,
        input logic [7:0] add,
        input logic [2:0] rot
    );
        return f_rotl(p ^ key, rot) + add;
    endfunction

    function automatic logic [7:0] f_decrypt(
        input logic [7:0] c,
        input logic [7:0] key,
        input logic [7:0] add,
        input logic [2:0] rot
    );
        return f_rotr(c - add, rot) ^ key;
    endfunction

    function automatic logic [7:0] f_hash(
        input logic [7:0] c,
        input logic [7:0] hkey
    );
        return (f_rotl(c, 3'd1) ^ hkey) + {c[3:0], c[7:4]};
    endfunction

endpackage

// File: rtl/cipher_hash_engine_if.sv
// Sample/result bundle between the capture logic (master)
// and the verification engine (slave).
interface cipher_hash_engine_if;

    logic       in_valid;
    logic [7:0] plain;
    logic [7:0] enc_in;
    logic [7:0] ref_hash;
    logic       out_valid;
    logic [7:0] dec_out;
    logic [7:0] reenc_out;
    logic [7:0] enc_out;
    logic [7:0] hash_out;
    logic       valid_flag;
    logic       enc_match;
    logic       hash_match;

    modport master (
        output in_valid, plain, enc_in, ref_hash,
        input  out_valid, dec_out, reenc_out, enc_out,
        input  hash_out, valid_flag, enc_match, hash_match
    );

    modport slave (
        input  in_valid, plain, enc_in, ref_hash,
        output out_valid, dec_out, reenc_out, enc_out,
        output hash_out, valid_flag, enc_match, hash_match
    );

endinterface

// File: rtl/cipher_hash_comb.sv
// Combinational transforms and compares for one sample:
// decrypt, re-encrypt, encrypt plain, keyed hash, flags.
module cipher_hash_comb
    import cipher_pkg::*;
#(
    parameter logic [7:0] KEY  = KEY_DEF,
    parameter logic [7:0] ADD  = ADD_DEF,
    parameter logic [2:0] ROT  = ROT_DEF,
    parameter logic [7:0] HKEY = HKEY_DEF
) (
    input  logic [7:0] plain,
    input  logic [7:0] enc_in,
    input  logic [7:0] ref_hash,
    output res_t       res
);

    // Build the full result bundle from the current inputs
    always_comb begin
        res            = '0;
        res.dec        = f_decrypt(enc_in, KEY, ADD, ROT);
        res.reenc      = f_encrypt(res.dec, KEY, ADD, ROT);
        res.enc        = f_encrypt(plain, KEY, ADD, ROT);
        res.hash       = f_hash(enc_in, HKEY);
        res.valid_flag = (res.dec == plain);
        res.enc_match  = (res.reenc == enc_in);
        res.hash_match = (res.hash == ref_hash);
    end

endmodule

// File: rtl/cipher_hash_engine.sv
// Registered cipher/hash verification engine: one-cycle
// latency, results held while no new sample arrives.
module cipher_hash_engine
    import cipher_pkg::*;
#(
    parameter logic [7:0] KEY  = KEY_DEF,
    parameter logic [7:0] ADD  = ADD_DEF,
    parameter logic [2:0] ROT  = ROT_DEF,
    parameter logic [7:0] HKEY = HKEY_DEF
) (
    input logic                  clk,
    input logic                  rst_n,
    cipher_hash_engine_if.slave  bus
);

    res_t res;
    res_t res_q;
    logic valid_q;

    cipher_hash_comb #(
        .KEY  (KEY),
        .ADD  (ADD),
        .ROT  (ROT),
        .HKEY (HKEY)
    ) u_comb (
        .plain    (bus.plain),
        .enc_in   (bus.enc_in),
        .ref_hash (bus.ref_hash),
        .res      (res)
    );

    // Capture results on a valid sample; reset wins over in_valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            res_q   <= '0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                res_q <= res;
            end
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.dec_out    = res_q.dec;
    assign bus.reenc_out  = res_q.reenc;
    assign bus.enc_out    = res_q.enc;
    assign bus.hash_out   = res_q.hash;
    assign bus.valid_flag = res_q.valid_flag;
    assign bus.enc_match  = res_q.enc_match;
    assign bus.hash_match = res_q.hash_match;

endmodule

// File: tb/tb_cipher_hash_engine.sv
// Scoreboard bench for cipher_hash_engine: directed vectors,
// exhaustive sweep, random ciphertexts, reset and hold cases.
module tb_cipher_hash_engine;

    typedef struct {
        logic [7:0] dec;
        logic [7:0] reenc;
        logic [7:0] enc;
        logic [7:0] hash;
        logic       vf;
        logic       em;
        logic       hm;
    } exp_t;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    exp_t sb[$];

    cipher_hash_engine_if bus ();

    cipher_hash_engine dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] m_enc(input logic [7:0] p);
        logic [7:0] x;
        x = p ^ 8'hA5;
        return {x[4:0], x[7:5]} + 8'h3C;
    endfunction

    function automatic logic [7:0] m_dec(input logic [7:0] c);
        logic [7:0] p;
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 256; i++) begin
            p = i[7:0];
            if (m_enc(p) == c) r = p;
        end
        return r;
    endfunction

    function automatic logic [7:0] m_hash(input logic [7:0] c);
        return ({c[6:0], c[7]} ^ 8'h5A) + {c[3:0], c[7:4]};
    endfunction

    task automatic chk(
        input string      name,
        input logic [7:0] act,
        input logic [7:0] exp
    );
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".out_valid"}, {7'd0, bus.out_valid}, 8'h00);
        chk({tag, ".dec_out"}, bus.dec_out, 8'h00);
        chk({tag, ".reenc_out"}, bus.reenc_out, 8'h00);
        chk({tag, ".enc_out"}, bus.enc_out, 8'h00);
        chk({tag, ".hash_out"}, bus.hash_out, 8'h00);
        chk({tag, ".flags"},
            {5'd0, bus.valid_flag, bus.enc_match, bus.hash_match},
            8'h00);
    endtask

    task automatic issue(
        input logic [7:0] p,
        input logic [7:0] c,
        input logic [7:0] h,
        input exp_t       e
    );
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.plain    = p;
        bus.enc_in   = c;
        bus.ref_hash = h;
        sb.push_back(e);
    endtask

    task automatic golden(input logic [7:0] c);
        exp_t e;
        e.dec   = m_dec(c);
        e.reenc = c;
        e.enc   = c;
        e.hash  = m_hash(c);
        e.vf    = 1'b1;
        e.em    = 1'b1;
        e.hm    = 1'b1;
        issue(e.dec, c, e.hash, e);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Monitor: pop and compare whenever a result is presented
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_valid: got 1 want 0 at %0t",
                             $time);
                end else begin
                    e = sb.pop_front();
                    chk("dec_out", bus.dec_out, e.dec);
                    chk("reenc_out", bus.reenc_out, e.reenc);
                    chk("enc_out", bus.enc_out, e.enc);
                    chk("hash_out", bus.hash_out, e.hash);
                    chk("valid_flag", {7'd0, bus.valid_flag}, {7'd0, e.vf});
                    chk("enc_match", {7'd0, bus.enc_match}, {7'd0, e.em});
                    chk("hash_match", {7'd0, bus.hash_match}, {7'd0, e.hm});
                end
            end
        end
    end

    initial begin
        errors       = 0;
        checks       = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.plain    = 8'h00;
        bus.enc_in   = 8'h69;
        bus.ref_hash = 8'h1E;
        @(posedge clk);
        #1;
        chk_zero("reset_with_valid");
        @(negedge clk);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;

        issue(8'h00, 8'h69, 8'h1E,
              '{8'h00, 8'h69, 8'h69, 8'h1E, 1'b1, 1'b1, 1'b1});
        issue(8'h3D, 8'h00, 8'h5A,
              '{8'h3D, 8'h00, 8'h00, 8'h5A, 1'b1, 1'b1, 1'b1});
        issue(8'hDD, 8'hFF, 8'hA4,
              '{8'hDD, 8'hFF, 8'hFF, 8'hA4, 1'b1, 1'b1, 1'b1});
        issue(8'h01, 8'h69, 8'h1F,
              '{8'h00, 8'h69, 8'h61, 8'h1E, 1'b0, 1'b1, 1'b0});

        idle();
        bus.plain    = 8'h55;
        bus.enc_in   = 8'hFF;
        bus.ref_hash = 8'h00;
        @(posedge clk);
        #1;
        chk("hold.out_valid", {7'd0, bus.out_valid}, 8'h00);
        chk("hold.dec_out", bus.dec_out, 8'h00);
        chk("hold.enc_out", bus.enc_out, 8'h61);
        chk("hold.hash_out", bus.hash_out, 8'h1E);
        chk("hold.flags",
            {5'd0, bus.valid_flag, bus.enc_match, bus.hash_match},
            8'h02);

        for (int i = 0; i < 256; i++) begin
            golden(i[7:0]);
        end
        for (int i = 0; i < 12; i++) begin
            golden(8'($urandom_range(0, 255)));
        end

        golden(8'h5A);
        @(negedge clk);
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.enc_in   = 8'h12;
        @(posedge clk);
        #1;
        chk_zero("reset_mid_stream");
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        issue(8'h00, 8'h69, 8'h1E,
              '{8'h00, 8'h69, 8'h69, 8'h1E, 1'b1, 1'b1, 1'b1});
        idle();
        repeat (3) @(negedge clk);

        chk("scoreboard_drained", 8'(sb.size()), 8'h00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
